// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter.
// Contains the FSM state type, the requester-count limit and the one-hot to index helper.
package mem_arb_pkg;

    localparam int NREQ_MAX = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory view.
interface mem_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection for the memory arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin from ptr+1; otherwise lowest index wins.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]  req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic [NREQ-1:0]  win
);

    localparam logic [NREQ-1:0] LSB_ONE = {{(NREQ-1){1'b0}}, 1'b1};

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W:0]   shift_s;
    logic [NREQ-1:0]  rot_s;
    logic [NREQ-1:0]  rot_win_s;

    // Rotate so ptr+1 sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        shift_s   = {1'b0, ptr} + {{IDX_W{1'b0}}, 1'b1};
        rot_s     = NREQ'({req, req} >> shift_s);
        rot_win_s = rot_s & (~rot_s + LSB_ONE);
        win       = NREQ'(({rot_win_s, rot_win_s} << shift_s) >> NREQ);
    end
`else
    // Lowest active index wins
    always_comb begin
        win = req & (~req + LSB_ONE);
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between NREQ requesters; each access is IDLE, ISSUE, RESP.
// Optional macro ARB_ROUND_ROBIN_EN builds the round-robin pointer; otherwise fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic         clk,
    input  logic         n_reset,
    mem_arbiter_if.slave bus
);

    arb_state_t       state_r;
    logic [NREQ-1:0]  win_s;
    logic [NREQ-1:0]  win_r;
    logic             we_s;
    logic             we_r;
    logic [AW-1:0]    addr_s;
    logic [DW-1:0]    wdata_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_r;

    arb_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req),
        .ptr (ptr_r),
        .win (win_s)
    );
`else
    arb_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req),
        .win (win_s)
    );
`endif

    // Mux the winner's access fields
    always_comb begin
        we_s    = 1'b0;
        addr_s  = {AW{1'b0}};
        wdata_s = {DW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            we_s    = we_s | (bus.req_we[k] & win_s[k]);
            addr_s  = addr_s | (bus.req_addr[k*AW +: AW] & {AW{win_s[k]}});
            wdata_s = wdata_s | (bus.req_wdata[k*DW +: DW] & {DW{win_s[k]}});
        end
    end

    // Read data is only meaningful in RESP of a read; rdata is decoded from state, never from req
    assign bus.rdata = ((state_r == RESP) && !we_r) ? bus.mem_rdata : {DW{1'b0}};

    // Access FSM with latched fields and registered outputs
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_r       <= IDLE;
            win_r         <= {NREQ{1'b0}};
            we_r          <= 1'b0;
            bus.gnt       <= {NREQ{1'b0}};
            bus.rvalid    <= {NREQ{1'b0}};
            bus.busy      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {AW{1'b0}};
            bus.mem_wdata <= {DW{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            ptr_r         <= IDX_W'(NREQ - 1);
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (|bus.req) begin
                        state_r       <= ISSUE;
                        win_r         <= win_s;
                        we_r          <= we_s;
                        bus.gnt       <= win_s;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= we_s;
                        bus.mem_addr  <= addr_s;
                        bus.mem_wdata <= wdata_s;
                        bus.busy      <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        ptr_r         <= onehot_to_idx(NREQ_MAX'(win_s));
`endif
                    end else begin
                        state_r  <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    state_r    <= RESP;
                    bus.gnt    <= {NREQ{1'b0}};
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    bus.rvalid <= win_r;
                    bus.busy   <= 1'b1;
                end
                RESP: begin
                    state_r    <= IDLE;
                    bus.rvalid <= {NREQ{1'b0}};
                    bus.busy   <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    bus.gnt    <= {NREQ{1'b0}};
                    bus.rvalid <= {NREQ{1'b0}};
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases then randomized traffic
// against a transaction-level model (winner rule, reference memory).
module tb_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MEMW = 64;

    logic clk;
    logic n_reset;
    logic ram_clear;

    mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    logic [DW-1:0] ram     [MEMW];
    logic [DW-1:0] ref_mem [MEMW];
    int n_checks;
    int n_pass;
    int last_win;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < MEMW; i++) ram[i] <= '0;
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[5:0]] <= bus.mem_wdata;
            else bus.mem_rdata <= ram[bus.mem_addr[5:0]];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
        int j;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NREQ; k++) begin
            j = (last + k) % NREQ;
            if (r[j]) return j;
        end
`else
        j = last;
        for (int k = 0; k < NREQ; k++) begin
            if (r[k]) return k;
        end
`endif
        return -1;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] bit_of(input int w);
        logic [NREQ-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    task automatic set_access(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.req[i]                = 1'b1;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic rand_access(input int i);
        set_access(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, MEMW - 1)), DW'($urandom));
    endtask

    task automatic raise_others(input int skip);
        for (int i = 0; i < NREQ; i++) begin
            if (i != skip && !bus.req[i] && $urandom_range(0, 9) < 3) rand_access(i);
        end
    endtask

    // One arbitration slot from an IDLE negedge. mode: 0 random, 1 winner re-presents, 2 winner drops
    task automatic run_slot(input int mode, output int obs);
        int w;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
        w = model_pick(bus.req, last_win);
        if (w < 0) begin
            @(negedge clk);
            obs = idx_of(bus.gnt);
            check_val("idle_gnt", 64'(bus.gnt), 64'd0);
            check_val("idle_busy", 64'(bus.busy), 64'd0);
            check_val("idle_mem_en", 64'(bus.mem_en), 64'd0);
            check_val("idle_rdata", 64'(bus.rdata), 64'd0);
            if (mode == 0) raise_others(-1);
            return;
        end
        we = bus.req_we[w];
        a  = bus.req_addr[w*AW +: AW];
        wd = bus.req_wdata[w*DW +: DW];
        @(negedge clk);
        obs = idx_of(bus.gnt);
        check_val("gnt", 64'(bus.gnt), 64'(bit_of(w)));
        check_val("mem_en", 64'(bus.mem_en), 64'd1);
        check_val("mem_we", 64'(bus.mem_we), 64'(we));
        check_val("mem_addr", 64'(bus.mem_addr), 64'(a));
        check_val("mem_wdata", 64'(bus.mem_wdata), 64'(wd));
        check_val("issue_busy", 64'(bus.busy), 64'd1);
        check_val("issue_rvalid", 64'(bus.rvalid), 64'd0);
        if ($urandom_range(0, 1) == 1) begin
            bus.req[w]                = 1'($urandom_range(0, 1));
            bus.req_we[w]             = ~we;
            bus.req_addr[w*AW +: AW]  = AW'($urandom);
            bus.req_wdata[w*DW +: DW] = DW'($urandom);
        end
        @(negedge clk);
        exp_rd = we ? '0 : ref_mem[a[5:0]];
        check_val("rvalid", 64'(bus.rvalid), 64'(bit_of(w)));
        check_val("rdata", 64'(bus.rdata), 64'(exp_rd));
        check_val("resp_gnt", 64'(bus.gnt), 64'd0);
        check_val("resp_mem_en", 64'(bus.mem_en), 64'd0);
        check_val("resp_busy", 64'(bus.busy), 64'd1);
        if (we) ref_mem[a[5:0]] = wd;
        last_win = w;
        case (mode)
            1: rand_access(w);
            2: bus.req[w] = 1'b0;
            default: begin
                if ($urandom_range(0, 1) == 1) rand_access(w);
                else bus.req[w] = 1'b0;
                raise_others(w);
            end
        endcase
        @(negedge clk);
        check_val("post_busy", 64'(bus.busy), 64'd0);
        check_val("post_rvalid", 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        int obs;
        int first;
        n_checks = 0;
        n_pass   = 0;
        n_reset   = 1'b0;
        ram_clear = 1'b1;
        bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < MEMW; i++) ref_mem[i] = '0;
        for (int i = 0; i < NREQ; i++) set_access(i, 1'b0, AW'(i), '0);
        repeat (2) @(negedge clk);
        check_val("rst_gnt", 64'(bus.gnt), 64'd0);
        check_val("rst_rvalid", 64'(bus.rvalid), 64'd0);
        check_val("rst_mem_en", 64'(bus.mem_en), 64'd0);
        check_val("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check_val("rst_rdata", 64'(bus.rdata), 64'd0);
        n_reset   = 1'b1;
        ram_clear = 1'b0;
        last_win  = NREQ - 1;
        run_slot(2, obs);
        check_val("first_grant", 64'(obs), 64'd0);
        run_slot(2, obs);
        run_slot(2, obs);
        run_slot(0, obs);

        // Preload 0x10, read it back via requester 1, then write/read 0x0
        set_access(0, 1'b1, 32'h10, 32'h0000_00FF);
        run_slot(2, obs);
        set_access(1, 1'b0, 32'h10, 32'h0);
        run_slot(2, obs);
        check_val("read_port", 64'(obs), 64'd1);
        set_access(2, 1'b1, 32'h0, 32'h0000_01FE);
        run_slot(2, obs);
        check_val("write_port", 64'(obs), 64'd2);
        set_access(0, 1'b0, 32'h0, 32'h0);
        run_slot(2, obs);

        // Contention with all three requesters active
        for (int i = 0; i < NREQ; i++) rand_access(i);
`ifdef ARB_ROUND_ROBIN_EN
        first = (last_win + 1) % NREQ;
        for (int s = 0; s < 2 * NREQ; s++) begin
            run_slot(1, obs);
            check_val("rr_order", 64'(obs), 64'((first + s) % NREQ));
        end
        bus.req = '0;
`else
        first = 0;
        for (int s = 0; s < NREQ; s++) begin
            run_slot(2, obs);
            check_val("fp_order", 64'(obs), 64'(first + s));
        end
`endif
        run_slot(0, obs);
        bus.req = '0;

        // Abort: reset during ISSUE, then re-arbitrate the same requester
        set_access(1, 1'b0, 32'h5, 32'h0);
        @(negedge clk);
        check_val("abort_gnt", 64'(bus.gnt), 64'(bit_of(1)));
        n_reset = 1'b0;
        @(negedge clk);
        check_val("abort_rvalid", 64'(bus.rvalid), 64'd0);
        check_val("abort_busy", 64'(bus.busy), 64'd0);
        check_val("abort_mem_en", 64'(bus.mem_en), 64'd0);
        n_reset  = 1'b1;
        last_win = NREQ - 1;
        run_slot(2, obs);
        check_val("abort_rearb", 64'(obs), 64'd1);

        // Randomized traffic
        for (int s = 0; s < 300; s++) run_slot(0, obs);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
